// File: rtl/debug_target_model.sv
`default_nettype none
// ============================================================================
// debug_target_model: cycle-accurate MCU stand-in for the UART debug controller
// Rev 1.0
// ============================================================================
module debug_target_model #(
    parameter int BUSY_CYCLES = 16,
    parameter int NUM_REGS    = 32,
    parameter int MEM_WORDS   = 256,
    parameter int PC_STEP     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    input  logic        pause,
    input  logic        resume,
    input  logic        reset,
    input  logic        reg_rd,
    input  logic        reg_wr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        mem_rw_byte,
    input  logic        valid,
    output logic        mcu_busy,
    output logic        error,
    output logic [31:0] pc,
    output logic [31:0] d_rd,
    output logic [2:0]  last_cmd,
    output logic [15:0] cmd_count,
    output logic [7:0]  err_count
);

    localparam int RIW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int MIW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW  = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

    localparam logic [2:0] CMD_PAUSE  = 3'd1;
    localparam logic [2:0] CMD_RESUME = 3'd2;
    localparam logic [2:0] CMD_REG_RD = 3'd3;
    localparam logic [2:0] CMD_REG_WR = 3'd4;
    localparam logic [2:0] CMD_MEM_RD = 3'd5;
    localparam logic [2:0] CMD_MEM_WR = 3'd6;
    localparam logic [2:0] CMD_RESET  = 3'd7;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        BUSY   = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              ret_paused;
    logic [2:0]        op;
    logic [CW-1:0]     cnt;
    logic [RIW-1:0]    op_reg;
    logic [MIW-1:0]    op_word;
    logic [1:0]        op_lane;
    logic              op_byte;
    logic [31:0]       op_data;
    logic [31:0]       regs [NUM_REGS];
    logic [31:0]       mem  [MEM_WORDS];

    logic [6:0]        strobes;
    logic [2:0]        code;
    logic              is_access, addr_oob, accept, reject, last_busy;
    logic [31:0]       mem_word;
    logic [7:0]        mem_byte;

    always_comb begin
        strobes = {reset, mem_wr, mem_rd, reg_wr, reg_rd, resume, pause};
        code    = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (strobes[i]) code = 3'(i + 1);
        end
        is_access = reg_rd | reg_wr | mem_rd | mem_wr;
        addr_oob  = ((reg_rd | reg_wr) && (addr >= 32'(NUM_REGS))) ||
                    ((mem_rd | mem_wr) && (addr >= 32'(4 * MEM_WORDS)));
        accept    = valid && (state != BUSY) && $onehot(strobes) &&
                    !(is_access && (state == RUN)) && !addr_oob;
        reject    = valid && !accept;
        last_busy = (state == BUSY) && (cnt == '0);
        mem_word  = mem[op_word];
        mem_byte  = mem_word[{op_lane, 3'b000} +: 8];

        state_next = state;
        if (accept) begin
            state_next = (code == CMD_RESUME) ? RUN : BUSY;
        end else if (last_busy) begin
            state_next = ret_paused ? PAUSED : RUN;
        end
    end

    assign mcu_busy = (state == BUSY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ret_paused <= 1'b0;
            op         <= 3'd0;
            cnt        <= '0;
            op_reg     <= '0;
            op_word    <= '0;
            op_lane    <= 2'd0;
            op_byte    <= 1'b0;
            op_data    <= 32'd0;
            pc         <= 32'd0;
            d_rd       <= 32'd0;
            error      <= 1'b0;
            last_cmd   <= 3'd0;
            cmd_count  <= 16'd0;
            err_count  <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
        end else begin
            error <= reject;
            if (reject && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

            if (accept) begin
                last_cmd <= code;
                if (cmd_count != 16'hFFFF) cmd_count <= cmd_count + 16'd1;
                if (code != CMD_RESUME) begin
                    // pause always lands in PAUSED; everything else returns where it started
                    ret_paused <= (code == CMD_PAUSE) || (state == PAUSED);
                    op         <= code;
                    cnt        <= CW'(BUSY_CYCLES - 1);
                    op_reg     <= addr[RIW-1:0];
                    op_word    <= addr[MIW+1:2];
                    op_lane    <= addr[1:0];
                    op_byte    <= mem_rw_byte;
                    op_data    <= d_in;
                end
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end

            if (state == RUN) begin
                pc <= pc + 32'(PC_STEP);
            end else if (last_busy && (op == CMD_RESET)) begin
                pc <= 32'd0;
            end

            if (last_busy) begin
                case (op)
                    CMD_REG_RD: d_rd <= regs[op_reg];
                    CMD_MEM_RD: d_rd <= op_byte ? {24'd0, mem_byte} : mem_word;
                    CMD_REG_WR: if (op_reg != '0) regs[op_reg] <= op_data;
                    CMD_RESET:  for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
                    default: ;
                endcase
            end
        end
    end

    // No reset on the array: contents survive both reset_n and the reset command
    always_ff @(posedge clk) begin
        if (last_busy && (op == CMD_MEM_WR)) begin
            if (op_byte) mem[op_word][{op_lane, 3'b000} +: 8] <= op_data[7:0];
            else         mem[op_word] <= op_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_target_model.sv
`default_nettype none
// Directed testbench for debug_target_model (default parameters).
module tb_debug_target_model;

    localparam logic [6:0] S_PAUSE  = 7'b0000001;
    localparam logic [6:0] S_RESUME = 7'b0000010;
    localparam logic [6:0] S_REG_RD = 7'b0000100;
    localparam logic [6:0] S_REG_WR = 7'b0001000;
    localparam logic [6:0] S_MEM_RD = 7'b0010000;
    localparam logic [6:0] S_MEM_WR = 7'b0100000;
    localparam logic [6:0] S_RESET  = 7'b1000000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] d_in = 32'd0;
    logic        pause = 1'b0, resume = 1'b0, rst_cmd = 1'b0;
    logic        reg_rd = 1'b0, reg_wr = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
    logic        mem_rw_byte = 1'b0, valid = 1'b0;
    logic        mcu_busy, error;
    logic [31:0] pc, d_rd;
    logic [2:0]  last_cmd;
    logic [15:0] cmd_count;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;
    int exp_err = 0;
    int exp_cmd = 0;

    always #5 clk = ~clk;

    debug_target_model dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .d_in(d_in),
        .pause(pause), .resume(resume), .reset(rst_cmd),
        .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rw_byte(mem_rw_byte), .valid(valid),
        .mcu_busy(mcu_busy), .error(error), .pc(pc), .d_rd(d_rd),
        .last_cmd(last_cmd), .cmd_count(cmd_count), .err_count(err_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic b);
        {rst_cmd, mem_wr, mem_rd, reg_wr, reg_rd, resume, pause} = s;
        addr = a; d_in = d; mem_rw_byte = b; valid = 1'b1;
        tick;
        valid = 1'b0;
        {rst_cmd, mem_wr, mem_rd, reg_wr, reg_rd, resume, pause} = 7'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (mcu_busy && n < 200) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) tick;
        checks++; if (mcu_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", mcu_busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", error); end
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc); end
        checks++; if (d_rd !== 32'd0) begin errors++; $display("FAIL rst_d_rd: got %h want 0", d_rd); end
        checks++; if (last_cmd !== 3'd0) begin errors++; $display("FAIL rst_last_cmd: got %0d want 0", last_cmd); end
        checks++; if (cmd_count !== 16'd0) begin errors++; $display("FAIL rst_cmd_count: got %0d want 0", cmd_count); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
    endtask

    task automatic test_run;
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick;
            checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL run_pc%0d: got %h want %h", i, pc, 32'(4 * i)); end
        end
        send(S_REG_RD, 32'd5, 32'd0, 1'b0);
        exp_err++;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL run_regrd_error: got %b want 1", error); end
        checks++; if (mcu_busy !== 1'b0) begin errors++; $display("FAIL run_regrd_busy: got %b want 0", mcu_busy); end
        checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL run_err_count: got %0d want %0d", err_count, exp_err); end
        tick;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL run_error_pulse: got %b want 0", error); end
    endtask

    task automatic test_pause;
        int n;
        logic [31:0] p;
        send(S_PAUSE, 32'd0, 32'd0, 1'b0);
        exp_cmd++;
        checks++; if (mcu_busy !== 1'b1) begin errors++; $display("FAIL pause_busy_rise: got %b want 1", mcu_busy); end
        wait_idle(n);
        checks++; if (n !== 16) begin errors++; $display("FAIL pause_busy_len: got %0d want 16", n); end
        p = pc;
        tick; tick;
        checks++; if (pc !== p) begin errors++; $display("FAIL pause_pc_frozen: got %h want %h", pc, p); end
        checks++; if (p === 32'd0) begin errors++; $display("FAIL pause_pc_nonzero: got %h want nonzero", p); end
        checks++; if (last_cmd !== 3'd1) begin errors++; $display("FAIL pause_last_cmd: got %0d want 1", last_cmd); end
        checks++; if (cmd_count !== 16'(exp_cmd)) begin errors++; $display("FAIL pause_cmd_count: got %0d want %0d", cmd_count, exp_cmd); end
    endtask

    task automatic test_regs;
        int n;
        send(S_REG_WR, 32'd5, 32'hDEADBEEF, 1'b0); wait_idle(n);
        send(S_REG_RD, 32'd5, 32'd0, 1'b0); wait_idle(n);
        exp_cmd += 2;
        checks++; if (d_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL reg5_rd: got %h want deadbeef", d_rd); end
        checks++; if (n !== 16) begin errors++; $display("FAIL regrd_busy_len: got %0d want 16", n); end
        checks++; if (last_cmd !== 3'd3) begin errors++; $display("FAIL regrd_last_cmd: got %0d want 3", last_cmd); end
        send(S_REG_WR, 32'd0, 32'h12345678, 1'b0); wait_idle(n);
        send(S_REG_RD, 32'd0, 32'd0, 1'b0); wait_idle(n);
        exp_cmd += 2;
        checks++; if (d_rd !== 32'd0) begin errors++; $display("FAIL reg0_rd: got %h want 0", d_rd); end
        checks++; if (cmd_count !== 16'(exp_cmd)) begin errors++; $display("FAIL regs_cmd_count: got %0d want %0d", cmd_count, exp_cmd); end
    endtask

    task automatic test_mem;
        int n;
        send(S_MEM_WR, 32'h10, 32'h11223344, 1'b0); wait_idle(n);
        send(S_MEM_WR, 32'h12, 32'h555555AA, 1'b1); wait_idle(n);
        send(S_MEM_RD, 32'h10, 32'd0, 1'b0); wait_idle(n);
        checks++; if (d_rd !== 32'h11AA3344) begin errors++; $display("FAIL mem_word_rd: got %h want 11aa3344", d_rd); end
        send(S_MEM_RD, 32'h13, 32'd0, 1'b1); wait_idle(n);
        checks++; if (d_rd !== 32'h00000011) begin errors++; $display("FAIL mem_byte_rd13: got %h want 00000011", d_rd); end
        send(S_MEM_RD, 32'h12, 32'd0, 1'b1); wait_idle(n);
        checks++; if (d_rd !== 32'h000000AA) begin errors++; $display("FAIL mem_byte_rd12: got %h want 000000aa", d_rd); end
        send(S_MEM_RD, 32'h13, 32'd0, 1'b0); wait_idle(n);
        checks++; if (d_rd !== 32'h11AA3344) begin errors++; $display("FAIL mem_word_unaligned: got %h want 11aa3344", d_rd); end
        exp_cmd += 6;
        checks++; if (last_cmd !== 3'd5) begin errors++; $display("FAIL mem_last_cmd: got %0d want 5", last_cmd); end
    endtask

    task automatic test_errors;
        int n;
        send(S_REG_RD, 32'd5, 32'd0, 1'b0);
        exp_cmd++;
        repeat (3) tick;
        send(S_REG_WR, 32'd5, 32'd0, 1'b0);
        exp_err++;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL midbusy_error: got %b want 1", error); end
        checks++; if (mcu_busy !== 1'b1) begin errors++; $display("FAIL midbusy_busy: got %b want 1", mcu_busy); end
        wait_idle(n);
        checks++; if (n !== 12) begin errors++; $display("FAIL midbusy_remaining: got %0d want 12", n); end
        checks++; if (d_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL midbusy_d_rd: got %h want deadbeef", d_rd); end
        send(S_REG_RD, 32'd5, 32'd0, 1'b0); wait_idle(n);
        exp_cmd++;
        checks++; if (d_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL midbusy_no_write: got %h want deadbeef", d_rd); end

        send(S_PAUSE | S_RESUME, 32'd0, 32'd0, 1'b0);
        exp_err++;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL two_strobes_error: got %b want 1", error); end
        send(7'd0, 32'd0, 32'd0, 1'b0);
        exp_err++;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL no_strobe_error: got %b want 1", error); end
        send(S_MEM_RD, 32'h400, 32'd0, 1'b0);
        exp_err++;
        checks++; if (error !== 1'b1 || mcu_busy !== 1'b0) begin errors++; $display("FAIL mem_oob: got err=%b busy=%b want err=1 busy=0", error, mcu_busy); end
        send(S_MEM_RD, 32'h3FC, 32'd0, 1'b0); wait_idle(n);
        exp_cmd++;
        checks++; if (n !== 16) begin errors++; $display("FAIL mem_top_ok: got busy_len=%0d want 16", n); end
        send(S_REG_RD, 32'd32, 32'd0, 1'b0);
        exp_err++;
        checks++; if (error !== 1'b1 || mcu_busy !== 1'b0) begin errors++; $display("FAIL reg_oob: got err=%b busy=%b want err=1 busy=0", error, mcu_busy); end
        send(S_REG_RD, 32'd31, 32'd0, 1'b0); wait_idle(n);
        exp_cmd++;
        checks++; if (n !== 16) begin errors++; $display("FAIL reg_top_ok: got busy_len=%0d want 16", n); end

        send(S_REG_RD, 32'd5, 32'd0, 1'b0);
        exp_cmd++;
        repeat (15) tick;
        checks++; if (mcu_busy !== 1'b1) begin errors++; $display("FAIL lastcyc_busy: got %b want 1", mcu_busy); end
        send(S_PAUSE, 32'd0, 32'd0, 1'b0);
        exp_err++;
        checks++; if (error !== 1'b1 || mcu_busy !== 1'b0) begin errors++; $display("FAIL lastcyc_reject: got err=%b busy=%b want err=1 busy=0", error, mcu_busy); end
        tick;
        checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL err_count: got %0d want %0d", err_count, exp_err); end
        checks++; if (cmd_count !== 16'(exp_cmd)) begin errors++; $display("FAIL cmd_count: got %0d want %0d", cmd_count, exp_cmd); end
    endtask

    task automatic test_reset_cmd;
        int n;
        logic [31:0] p;
        p = pc;
        checks++; if (p === 32'd0) begin errors++; $display("FAIL rcmd_pc_before: got %h want nonzero", p); end
        send(S_RESET, 32'd0, 32'd0, 1'b0); wait_idle(n);
        checks++; if (n !== 16) begin errors++; $display("FAIL rcmd_busy_len: got %0d want 16", n); end
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL rcmd_pc: got %h want 0", pc); end
        checks++; if (last_cmd !== 3'd7) begin errors++; $display("FAIL rcmd_last_cmd: got %0d want 7", last_cmd); end
        send(S_REG_RD, 32'd5, 32'd0, 1'b0); wait_idle(n);
        checks++; if (d_rd !== 32'd0 || n !== 16) begin errors++; $display("FAIL rcmd_reg_clear: got d_rd=%h busy_len=%0d want 0/16", d_rd, n); end
        send(S_MEM_RD, 32'h10, 32'd0, 1'b0); wait_idle(n);
        checks++; if (d_rd !== 32'h11AA3344) begin errors++; $display("FAIL rcmd_mem_kept: got %h want 11aa3344", d_rd); end
        tick; tick;
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL rcmd_still_paused: got %h want 0", pc); end
        send(S_RESUME, 32'd0, 32'd0, 1'b0);
        checks++; if (pc !== 32'd0 || mcu_busy !== 1'b0) begin errors++; $display("FAIL resume_t1: got pc=%h busy=%b want 0/0", pc, mcu_busy); end
        checks++; if (last_cmd !== 3'd2) begin errors++; $display("FAIL resume_last_cmd: got %0d want 2", last_cmd); end
        tick;
        checks++; if (pc !== 32'd4) begin errors++; $display("FAIL resume_t2: got %h want 4", pc); end
        tick;
        checks++; if (pc !== 32'd8) begin errors++; $display("FAIL resume_t3: got %h want 8", pc); end
    endtask

    task automatic test_async_reset;
        int n;
        send(S_PAUSE, 32'd0, 32'd0, 1'b0); wait_idle(n);
        send(S_REG_WR, 32'd7, 32'hCAFEF00D, 1'b0);
        repeat (5) tick;
        reset_n = 1'b0;
        #1;
        checks++; if (mcu_busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL ares_busy_err: got busy=%b err=%b want 0/0", mcu_busy, error); end
        checks++; if (pc !== 32'd0 || d_rd !== 32'd0) begin errors++; $display("FAIL ares_pc_drd: got pc=%h d_rd=%h want 0/0", pc, d_rd); end
        checks++; if (last_cmd !== 3'd0 || cmd_count !== 16'd0 || err_count !== 8'd0) begin errors++; $display("FAIL ares_counts: got last=%0d cmd=%0d err=%0d want 0/0/0", last_cmd, cmd_count, err_count); end
        repeat (20) tick;
        reset_n = 1'b1;
        tick;
        send(S_PAUSE, 32'd0, 32'd0, 1'b0); wait_idle(n);
        send(S_REG_RD, 32'd7, 32'd0, 1'b0); wait_idle(n);
        checks++; if (d_rd !== 32'd0 || n !== 16) begin errors++; $display("FAIL ares_reg7: got d_rd=%h busy_len=%0d want 0/16", d_rd, n); end
        checks++; if (cmd_count !== 16'd2) begin errors++; $display("FAIL ares_cmd_count: got %0d want 2", cmd_count); end
    endtask

    initial begin
        test_reset;
        test_run;
        test_pause;
        test_regs;
        test_mem;
        test_errors;
        test_reset_cmd;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debug_target_model.md
# debug_target_model

Parametrised, cycle-accurate stand-in for the RISC-V MCU behind `mcu_controller`. It accepts the controller's command strobes and models the MCU side of the debug link: the run/pause state, a PC, a register file, word/byte memory, a programmable busy latency and error reporting. It feeds the real `d_rd`, `mcu_busy`, `error` and `pc` back to the controller, so the UART debugger can be exercised end-to-end on the board or in simulation without the CPU.

## Interface
Parameters:
- BUSY_CYCLES, 16: cycles `mcu_busy` stays high per accepted pause/reset/reg/mem command; legal range ≥1.
- NUM_REGS, 32: register-file entries; power of two, ≤32.
- MEM_WORDS, 256: 32-bit memory words; power of two.
- PC_STEP, 4: PC increment per cycle while running.

Ports:
- clk  in  1  single clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  32  register index or byte address for the command.
- d_in  in  32  write data.
- pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr  in  1 each  command strobes; sampled only when `valid`=1.
- mem_rw_byte  in  1  byte-mode qualifier for mem_rd/mem_wr.
- valid  in  1  command qualifier, one-cycle pulse.
- mcu_busy  out  1  command in progress.
- error  out  1  one-cycle rejection pulse.
- pc  out  32  model program counter.
- d_rd  out  32  read result.
- last_cmd  out  3  code of the last accepted command: 1 pause, 2 resume, 3 reg_rd, 4 reg_wr, 5 mem_rd, 6 mem_wr, 7 reset.
- cmd_count  out  16  accepted commands, saturates at 0xFFFF.
- err_count  out  8  rejected commands, saturates at 0xFF.

## Operation
- FSM states: RUN, PAUSED, BUSY. BUSY records its return state (RUN or PAUSED) and the pending operation.
- RUN: `pc <= pc + PC_STEP` every cycle, wrapping modulo 2^32. PAUSED and BUSY: `pc` frozen.
- A command is accepted when `valid`=1, exactly one strobe is set and the FSM is not in BUSY. Accepting it updates `last_cmd` and `cmd_count`.
- Rejections assert `error` and increment `err_count`; no state changes. Causes:
  - `valid` while in BUSY;
  - zero or more than one strobe set;
  - reg_rd, reg_wr, mem_rd or mem_wr while in RUN;
  - register index `addr` ≥ NUM_REGS;
  - memory byte address ≥ 4·MEM_WORDS.
- pause: BUSY → PAUSED. pause while already PAUSED is accepted and returns to PAUSED.
- resume: no BUSY phase; the state is RUN from the next cycle. resume while in RUN is accepted as a no-op.
- reset command: BUSY; at completion `pc`=0 and all registers are cleared; memory is kept. Returns to the pre-command run/pause state.
- reg_rd / reg_wr: register 0 reads 0 and ignores writes.
- mem_rd / mem_wr: word index = `addr[log2(MEM_WORDS)+1:2]`.
  - Word mode: ignores `addr[1:0]`.
  - Byte mode write: writes `d_in[7:0]` into lane `addr[1:0]`; other lanes are unchanged.
  - Byte mode read: returns the lane zero-extended.
- Writes commit and read results load `d_rd` on the final BUSY cycle. `d_rd` otherwise holds its value.
- `reset_n` low at any time, including mid-BUSY: the in-flight operation is abandoned with no commit.

## Timing
- Reset values: `mcu_busy` 0, `error` 0, `pc` 0, `d_rd` 0, `last_cmd` 0, `cmd_count` 0, `err_count` 0, state RUN. Register file reset to 0; memory contents undefined.
- `mcu_busy` rises the cycle after acceptance and stays high exactly BUSY_CYCLES cycles.
- `d_rd` and memory/register contents are updated on the clock edge where `mcu_busy` falls. A command is accepted on that same cycle at the earliest.
- `error` is high the cycle after the offending `valid`, for exactly one cycle.
- The resume transition is visible on `pc` (incrementing) two cycles after `valid`.
- `valid` high in the cycle BUSY ends is still rejected (the FSM is in BUSY when it is sampled).

## Test plan
- Release reset → `pc` counts 0, 4, 8, …; reg_rd while in RUN → `error` pulse, `err_count`=1, `mcu_busy` stays 0.
- pause → `mcu_busy` high for 16 cycles, then `pc` frozen; reg_wr addr=5 d_in=0xDEADBEEF, then reg_rd addr=5 → `d_rd`=0xDEADBEEF when `mcu_busy` falls; reg_wr addr=0 then reg_rd addr=0 → `d_rd`=0.
- In PAUSED: mem_wr word 0x10=0x11223344, then byte mem_wr addr=0x12 d_in=0xAA, then word mem_rd 0x10 → 0x11AA3344; byte mem_rd 0x13 → 0x00000011.
- Second `valid` mid-BUSY → `error`, original command completes unaffected; `valid` with pause and resume both set → `error`; mem_rd addr=0x400 (MEM_WORDS=256) → `error`.
- reset command while PAUSED with `pc`≠0 → `pc`=0, registers read 0, earlier memory data intact, state still PAUSED; resume → `pc` increments again.
- Assert `reset_n` mid-way through a reg_wr BUSY phase → all outputs take their reset values; a later reg_rd of that register → 0.
